// File: rtl/lsu_align_pkg.sv
// Shared types and sizing helpers for the LSU alignment unit.
package lsu_align_pkg;

  localparam int unsigned SIZE_MAX_W = 8;
  localparam int unsigned MASK_MAX_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_RESP
  } state_t;

  function automatic int unsigned off_width(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  // One-hot size code to byte count.
  function automatic int unsigned size_to_bytes(input logic [SIZE_MAX_W-1:0] size);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < SIZE_MAX_W; i++)
      if (size[i]) n = 32'd1 << i;
    return n;
  endfunction

  function automatic logic [MASK_MAX_W-1:0] size_to_mask(input int unsigned n);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_MAX_W; i++)
      if (i < n) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/lsu_align_unit_if.sv
// LSU request/response and BIU bus signals of the alignment unit.
interface lsu_align_unit_if
  import lsu_align_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64
);
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = off_width(DATA_W);

  logic              lsu_valid;
  logic              lsu_ready;
  logic              lsu_wr;
  logic              lsu_unsign;
  logic [OFF_W:0]    lsu_size;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_misalign;
  logic              biu_req;
  logic              biu_wr;
  logic [ADDR_W-1:0] biu_addr;
  logic [BYTES-1:0]  biu_be;
  logic [DATA_W-1:0] biu_wdata;
  logic              biu_ack;
  logic [DATA_W-1:0] biu_rdata;

  modport master (
    output lsu_valid, lsu_wr, lsu_unsign, lsu_size, lsu_addr, lsu_wdata, biu_ack, biu_rdata,
    input  lsu_ready, resp_valid, resp_rdata, resp_misalign,
    input  biu_req, biu_wr, biu_addr, biu_be, biu_wdata
  );

  modport slave (
    input  lsu_valid, lsu_wr, lsu_unsign, lsu_size, lsu_addr, lsu_wdata, biu_ack, biu_rdata,
    output lsu_ready, resp_valid, resp_rdata, resp_misalign,
    output biu_req, biu_wr, biu_addr, biu_be, biu_wdata
  );

endinterface

// File: rtl/lsu_align_unit_extend.sv
// lsu_extend: right-shifts a two-word window by a byte offset, keeps n bytes and
// sign- or zero-extends them to a full bus word.
module lsu_extend
  import lsu_align_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [2*DATA_W-1:0]         data,
  input  logic [off_width(DATA_W)-1:0] off,
  input  logic [off_width(DATA_W):0]   n,
  input  logic                        unsign,
  output logic [DATA_W-1:0]           result
);
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = off_width(DATA_W);

  logic [DATA_W-1:0] shifted;
  logic              sign;

  always_comb begin
    shifted = DATA_W'(data >> {off, 3'b000});
    sign    = 1'b0;
    for (int unsigned i = 0; i < BYTES; i++)
      if (n == (OFF_W+1)'(i + 1)) sign = shifted[8*i+7];
    result = '0;
    for (int unsigned i = 0; i < BYTES; i++)
      result[8*i +: 8] = ((OFF_W+1)'(i) < n) ? shifted[8*i +: 8] : {8{sign & ~unsign}};
  end

endmodule

// File: rtl/lsu_align_unit.sv
// Load/store alignment unit between LSU and BIU.
// Build option MISALIGN_SPLIT_EN: word-crossing accesses run as two merged bus beats.
module lsu_align_unit
  import lsu_align_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 64
) (
  input logic             clk,
  input logic             rst_n,
  lsu_align_unit_if.slave bus
);
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = off_width(DATA_W);

  state_t            state;
  logic [OFF_W-1:0]  req_off;
  logic [OFF_W:0]    req_n;
  logic              req_unsign;
  logic              req_wr;

  logic [OFF_W-1:0]  acc_off;
  logic [OFF_W:0]    acc_n;
  logic [OFF_W+1:0]  acc_end;
  logic              acc_cross;
  logic              acc_bad;
  logic [BYTES-1:0]  acc_mask;
  logic [ADDR_W-1:0] acc_addr_al;
  logic              beat_last;
  logic [2*DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] ext_result;

`ifdef MISALIGN_SPLIT_EN
  logic              req_cross;
  logic [ADDR_W-1:0] req_addr_al;
  logic [BYTES-1:0]  req_mask;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] buf_l;
  logic [OFF_W:0]    hi_shift;
  logic [BYTES-1:0]  hi_be;
  logic [DATA_W-1:0] hi_wdata;
`endif

  // Decode of the request presented at the LSU port.
  always_comb begin
    acc_off     = bus.lsu_addr[OFF_W-1:0];
    acc_n       = (OFF_W+1)'(size_to_bytes(SIZE_MAX_W'(bus.lsu_size)));
    acc_end     = (OFF_W+2)'(acc_off) + (OFF_W+2)'(acc_n);
    acc_cross   = acc_end > (OFF_W+2)'(BYTES);
    acc_mask    = BYTES'(size_to_mask(32'(acc_n)));
    acc_addr_al = {bus.lsu_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
`ifdef MISALIGN_SPLIT_EN
    acc_bad     = !$onehot(bus.lsu_size);
`else
    acc_bad     = !$onehot(bus.lsu_size) || acc_cross;
`endif
  end

  // Result is merged straight from the acking beat so the response follows the ack by one cycle.
  always_comb begin
`ifdef MISALIGN_SPLIT_EN
    hi_shift  = (OFF_W+1)'(BYTES) - (OFF_W+1)'(req_off);
    hi_be     = req_mask >> hi_shift;
    hi_wdata  = req_wdata >> {hi_shift, 3'b000};
    beat_last = (state == ST_BEAT1) || !req_cross;
    ext_data  = (state == ST_BEAT1) ? {bus.biu_rdata, buf_l} : {DATA_W'(0), bus.biu_rdata};
`else
    beat_last = 1'b1;
    ext_data  = {DATA_W'(0), bus.biu_rdata};
`endif
  end

  lsu_extend #(.DATA_W(DATA_W)) u_extend (
    .data   (ext_data),
    .off    (req_off),
    .n      (req_n),
    .unsign (req_unsign),
    .result (ext_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      req_off           <= '0;
      req_n             <= '0;
      req_unsign        <= 1'b0;
      req_wr            <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      req_cross         <= 1'b0;
      req_addr_al       <= '0;
      req_mask          <= '0;
      req_wdata         <= '0;
      buf_l             <= '0;
`endif
      bus.lsu_ready     <= 1'b1;
      bus.resp_valid    <= 1'b0;
      bus.resp_rdata    <= '0;
      bus.resp_misalign <= 1'b0;
      bus.biu_req       <= 1'b0;
      bus.biu_wr        <= 1'b0;
      bus.biu_addr      <= '0;
      bus.biu_be        <= '0;
      bus.biu_wdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.lsu_valid) begin
          req_off        <= acc_off;
          req_n          <= acc_n;
          req_unsign     <= bus.lsu_unsign;
          req_wr         <= bus.lsu_wr;
`ifdef MISALIGN_SPLIT_EN
          req_cross      <= acc_cross;
          req_addr_al    <= acc_addr_al;
          req_mask       <= acc_mask;
          req_wdata      <= bus.lsu_wdata;
`endif
          bus.lsu_ready  <= 1'b0;
          bus.resp_rdata <= '0;
          if (acc_bad) begin
            state             <= ST_RESP;
            bus.resp_valid    <= 1'b1;
            bus.resp_misalign <= 1'b1;
          end else begin
            state         <= ST_BEAT0;
            bus.biu_req   <= 1'b1;
            bus.biu_wr    <= bus.lsu_wr;
            bus.biu_addr  <= acc_addr_al;
            bus.biu_be    <= acc_mask << acc_off;
            bus.biu_wdata <= bus.lsu_wdata << {acc_off, 3'b000};
          end
        end
        ST_BEAT0, ST_BEAT1: if (bus.biu_ack) begin
          if (beat_last) begin
            state          <= ST_RESP;
            bus.biu_req    <= 1'b0;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= req_wr ? '0 : ext_result;
          end
`ifdef MISALIGN_SPLIT_EN
          else begin
            state         <= ST_BEAT1;
            buf_l         <= bus.biu_rdata;
            bus.biu_addr  <= req_addr_al + ADDR_W'(BYTES);
            bus.biu_be    <= hi_be;
            bus.biu_wdata <= hi_wdata;
          end
`endif
        end
        ST_RESP: begin
          state             <= ST_IDLE;
          bus.lsu_ready     <= 1'b1;
          bus.resp_valid    <= 1'b0;
          bus.resp_misalign <= 1'b0;
          bus.resp_rdata    <= '0;
        end
        default: begin
          state         <= ST_IDLE;
          bus.lsu_ready <= 1'b1;
          bus.biu_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Randomized bench for lsu_align_unit against a byte-addressed memory model.
module tb_lsu_align_unit;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 64;
`ifdef MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] mem [logic [63:0]];

  lsu_align_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  lsu_align_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic int size_bytes(input logic [3:0] size);
    case (size)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 4;
      4'b1000: return 8;
      default: return 0;
    endcase
  endfunction

  // One LSU access; the bench acts as BIU and checks every beat against the byte model.
  task automatic do_access(input bit wr, input bit uns, input logic [3:0] size,
                           input logic [63:0] addr, input logic [63:0] wdata, input int dly,
                           input bit noise,
                           output logic [63:0] rdata, output bit mis, output int nbeats,
                           output logic [7:0] be0, output logic [7:0] be1,
                           output logic [63:0] wd0, output logic [63:0] wd1);
    int n, wcnt, ack_cyc, first_req;
    bit exp_mis, exp_cross, got, in_beat, stable;
    logic [63:0] exp_rd, exp_wa, exp_wd, wmask, h_addr, h_wd;
    logic [7:0]  exp_be, h_be;
    logic        h_wr;
    n         = size_bytes(size);
    exp_cross = (n != 0) && (int'(addr[2:0]) + n > 8);
    exp_mis   = (n == 0) || (!SPLIT && exp_cross);
    exp_rd    = '0;
    if (!wr && n != 0) begin
      for (int i = 0; i < n; i++) exp_rd |= 64'(rd_byte(addr + 64'(i))) << (8 * i);
      if (!uns && n < 8 && exp_rd[8*n-1]) exp_rd |= ~((64'd1 << (8 * n)) - 64'd1);
    end
    rdata = '0; mis = 1'b0; nbeats = 0; be0 = '0; be1 = '0; wd0 = '0; wd1 = '0;
    got = 1'b0; in_beat = 1'b0; wcnt = 0; ack_cyc = -100; first_req = -1;
    h_addr = '0; h_wd = '0; h_be = '0; h_wr = 1'b0;

    @(negedge clk);
    check("ready_idle", 64'(bus.lsu_ready), 64'd1);
    bus.lsu_valid = 1'b1; bus.lsu_wr = wr; bus.lsu_unsign = uns;
    bus.lsu_size = size; bus.lsu_addr = addr; bus.lsu_wdata = wdata;
    @(negedge clk);
    bus.lsu_valid = 1'b0;
    check("ready_busy", 64'(bus.lsu_ready), 64'd0);

    for (int cyc = 0; cyc < 64 && !got; cyc++) begin
      bus.biu_ack   = 1'b0;
      bus.biu_rdata = {$urandom, $urandom};
      bus.lsu_valid = noise;
      if (noise) begin
        bus.lsu_wr = 1'($urandom); bus.lsu_unsign = 1'($urandom);
        bus.lsu_size = 4'($urandom); bus.lsu_addr = {$urandom, $urandom};
        bus.lsu_wdata = {$urandom, $urandom};
      end
      if (bus.resp_valid) begin
        got = 1'b1; bus.lsu_valid = 1'b0;
        rdata = bus.resp_rdata; mis = bus.resp_misalign;
        if (exp_mis) check("mis_latency", 64'(cyc), 64'd0);
        else         check("ack_latency", 64'(cyc - ack_cyc), 64'd1);
      end else if (bus.biu_req) begin
        if (first_req < 0) first_req = cyc;
        if (!in_beat) begin
          in_beat = 1'b1; wcnt = 0;
          h_addr = bus.biu_addr; h_be = bus.biu_be; h_wd = bus.biu_wdata; h_wr = bus.biu_wr;
          exp_wa = (addr & ~64'd7) + ((nbeats == 0) ? 64'd0 : 64'd8);
          exp_be = '0; exp_wd = '0; wmask = '0;
          for (int j = 0; j < 8; j++) begin
            logic [63:0] d;
            d = exp_wa + 64'(j) - addr;
            if (d < 64'(n)) begin
              exp_be[j] = 1'b1;
              wmask[8*j +: 8] = 8'hFF;
              exp_wd[8*j +: 8] = wdata[8*int'(d[2:0]) +: 8];
            end
          end
          check("beat_addr", bus.biu_addr, exp_wa);
          check("beat_be", 64'(bus.biu_be), 64'(exp_be));
          check("beat_wr", 64'(bus.biu_wr), 64'(wr));
          if (wr) check("beat_wdata", bus.biu_wdata & wmask, exp_wd);
          if (nbeats == 0) begin be0 = bus.biu_be; wd0 = bus.biu_wdata; end
          else             begin be1 = bus.biu_be; wd1 = bus.biu_wdata; end
          nbeats++;
        end else begin
          stable = (bus.biu_addr === h_addr) && (bus.biu_be === h_be) &&
                   (bus.biu_wdata === h_wd) && (bus.biu_wr === h_wr);
          check("beat_hold", 64'(stable), 64'd1);
        end
        if (wcnt == dly) begin
          bus.biu_ack = 1'b1;
          for (int j = 0; j < 8; j++) begin
            bus.biu_rdata[8*j +: 8] = rd_byte(bus.biu_addr + 64'(j));
            if (bus.biu_wr && bus.biu_be[j]) mem[bus.biu_addr + 64'(j)] = bus.biu_wdata[8*j +: 8];
          end
          in_beat = 1'b0; ack_cyc = cyc;
        end
        wcnt++;
      end
      if (!got) @(negedge clk);
    end

    bus.lsu_valid = 1'b0;
    if (!got) check("resp_timeout", 64'd0, 64'd1);
    check("misalign", 64'(mis), 64'(exp_mis));
    check("beats", 64'(nbeats), exp_mis ? 64'd0 : (exp_cross ? 64'd2 : 64'd1));
    if (!exp_mis) begin
      check("req_latency", 64'(first_req), 64'd0);
      check("rdata", rdata, wr ? 64'd0 : exp_rd);
    end
    @(negedge clk);
    check("resp_pulse", 64'(bus.resp_valid), 64'd0);
    check("ready_back", 64'(bus.lsu_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] rd, wd0, wd1, a, wdat;
    logic [7:0]  be0, be1;
    logic [3:0]  sz;
    bit          mis, wr, uns;
    int          nb, r;

    rst_n = 1'b0;
    bus.lsu_valid = 1'b0; bus.lsu_wr = 1'b0; bus.lsu_unsign = 1'b0; bus.lsu_size = '0;
    bus.lsu_addr = '0; bus.lsu_wdata = '0; bus.biu_ack = 1'b0; bus.biu_rdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.lsu_ready), 64'd1);
    check("rst_req", 64'(bus.biu_req), 64'd0);
    check("rst_resp", 64'(bus.resp_valid), 64'd0);
    check("rst_mis", 64'(bus.resp_misalign), 64'd0);
    check("rst_rdata", bus.resp_rdata, 64'd0);
    check("rst_bus", {bus.biu_addr[55:0], bus.biu_be}, 64'd0);
    rst_n = 1'b1;

    // Ack with no outstanding request must be ignored.
    @(negedge clk);
    bus.biu_ack = 1'b1; bus.biu_rdata = '1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stray_ack_resp", 64'(bus.resp_valid), 64'd0);
    end
    bus.biu_ack = 1'b0;

    mem[64'h1003] = 8'h80;
    do_access(1'b0, 1'b0, 4'b0001, 64'h1003, 64'd0, 0, 1'b0, rd, mis, nb, be0, be1, wd0, wd1);
    check("t1_be", 64'(be0), 64'h08);
    check("t1_rdata", rd, 64'hFFFF_FFFF_FFFF_FF80);

    mem[64'h6] = 8'h34; mem[64'h7] = 8'h12;
    do_access(1'b0, 1'b1, 4'b0010, 64'h6, 64'd0, 2, 1'b0, rd, mis, nb, be0, be1, wd0, wd1);
    check("t2_be", 64'(be0), 64'hC0);
    check("t2_rdata", rd, 64'h1234);

    mem[64'h0E] = 8'h78; mem[64'h0F] = 8'h56; mem[64'h10] = 8'h34; mem[64'h11] = 8'h12;
`ifdef MISALIGN_SPLIT_EN
    do_access(1'b0, 1'b0, 4'b0100, 64'h0E, 64'd0, 1, 1'b0, rd, mis, nb, be0, be1, wd0, wd1);
    check("t3_be0", 64'(be0), 64'hC0);
    check("t3_be1", 64'(be1), 64'h03);
    check("t3_rdata", rd, 64'h1234_5678);

    do_access(1'b1, 1'b0, 4'b1000, 64'h5, 64'h1122_3344_5566_7788, 3, 1'b1, rd, mis, nb, be0, be1, wd0, wd1);
    check("t4_be0", 64'(be0), 64'hE0);
    check("t4_wd0", 64'(wd0[63:40]), 64'h66_7788);
    check("t4_be1", 64'(be1), 64'h1F);
    check("t4_wd1", 64'(wd1[39:0]), 64'h11_2233_4455);
    do_access(1'b0, 1'b0, 4'b1000, 64'h5, 64'd0, 0, 1'b0, rd, mis, nb, be0, be1, wd0, wd1);
    check("t4_readback", rd, 64'h1122_3344_5566_7788);
`else
    do_access(1'b0, 1'b0, 4'b0100, 64'h0E, 64'd0, 1, 1'b0, rd, mis, nb, be0, be1, wd0, wd1);
    check("t5_mis", 64'(mis), 64'd1);
    check("t5_beats", 64'(nb), 64'd0);
`endif
    do_access(1'b0, 1'b0, 4'b0110, 64'h0E, 64'd0, 0, 1'b0, rd, mis, nb, be0, be1, wd0, wd1);
    check("t5_size_mis", 64'(mis), 64'd1);
    check("t5_size_beats", 64'(nb), 64'd0);

    // Reset in the last beat of an outstanding access.
    @(negedge clk);
    bus.lsu_valid = 1'b1; bus.lsu_wr = 1'b0; bus.lsu_unsign = 1'b0;
`ifdef MISALIGN_SPLIT_EN
    bus.lsu_size = 4'b0100; bus.lsu_addr = 64'h0E;
`else
    bus.lsu_size = 4'b1000; bus.lsu_addr = 64'h20;
`endif
    @(negedge clk);
    bus.lsu_valid = 1'b0;
    check("t6_req", 64'(bus.biu_req), 64'd1);
`ifdef MISALIGN_SPLIT_EN
    bus.biu_ack = 1'b1;
    @(negedge clk);
    bus.biu_ack = 1'b0;
    check("t6_beat1_addr", bus.biu_addr, 64'h10);
`endif
    rst_n = 1'b0;
    #1;
    check("t6_req_drop", 64'(bus.biu_req), 64'd0);
    check("t6_ready", 64'(bus.lsu_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_no_resp", 64'(bus.resp_valid), 64'd0);
    end
    rst_n = 1'b1;
    do_access(1'b0, 1'b0, 4'b1000, 64'h20, 64'd0, 1, 1'b0, rd, mis, nb, be0, be1, wd0, wd1);

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 8);
      if (r == 8) sz = 4'($urandom_range(0, 15));
      else        sz = 4'(1 << (r % 4));
      if ($urandom_range(0, 9) == 0) a = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      else                           a = 64'h1000 + 64'($urandom_range(0, 47));
      wr   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      wdat = {$urandom, $urandom};
      do_access(wr, uns, sz, a, wdat, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                rd, mis, nb, be0, be1, wd0, wd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
